// File: rtl/lavadora_pkg.sv
// Shared definitions for the washing-machine sequencing controller.
// Holds the phase encoding, the phase-counter width and the default
// phase durations used as parameter defaults by controlador_ciclo.
package lavadora_pkg;

    localparam int unsigned LARGURA_CONT = 8;

    localparam int unsigned TEMPO_ENCHER_MAX_PADRAO  = 20;
    localparam int unsigned TEMPO_MOLHO_PADRAO       = 4;
    localparam int unsigned TEMPO_LAVAGEM_PADRAO     = 5;
    localparam int unsigned TEMPO_DRENAR_PADRAO      = 3;
    localparam int unsigned TEMPO_CENTRIFUGAR_PADRAO = 6;

    typedef enum logic [2:0] {
        FASE_IDLE        = 3'd0,
        FASE_ENCHER      = 3'd1,
        FASE_MOLHO       = 3'd2,
        FASE_LAVAR       = 3'd3,
        FASE_DRENAR      = 3'd4,
        FASE_CENTRIFUGAR = 3'd5,
        FASE_FIM         = 3'd6,
        FASE_ERRO        = 3'd7
    } fase_t;

    // Timed phases: the only ones that can pause and that use the counter.
    function automatic logic fase_temporizada(input fase_t f);
        return (f == FASE_ENCHER) || (f == FASE_MOLHO) || (f == FASE_LAVAR) ||
               (f == FASE_DRENAR) || (f == FASE_CENTRIFUGAR);
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Phase timer shared by every timed phase of controlador_ciclo.
// Ports:
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_limpar     clear the count to 0 (phase entry)
//   i_habilitar  count this cycle (phase active and not paused)
//   i_terminal   terminal count (phase length - 1)
//   fim_tempo    count equals terminal
module temporizador_fase
    import lavadora_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_limpar,
    input  logic                    i_habilitar,
    input  logic [LARGURA_CONT-1:0] i_terminal,
    output logic                    fim_tempo
);

    logic [LARGURA_CONT-1:0] r_contagem;

    // The count holds at the terminal value so that a pause taken on a
    // phase's final cycle resumes into that same final cycle without wrapping.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_contagem <= '0;
        end else if (i_limpar) begin
            r_contagem <= '0;
        end else if (i_habilitar && !fim_tempo) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

    assign fim_tempo = (r_contagem == i_terminal);

endmodule

// File: rtl/controlador_ciclo.sv
// Washing-machine programme sequencer: fill, optional soak, wash, drain,
// spin. Drives all actuators, owns phase timing, pauses on door open and
// faults on fill timeout.
// Build option: define CICLO_MOLHO_EN to include the soak (MOLHO) phase;
// without it ENCHER goes straight to LAVAR.
// Ports:
//   clock, reset_n           clock (rising edge), async active-low reset
//   start                    level programme request
//   porta_fechada            door closed sensor (1 = closed)
//   nivel_cheio              water level full sensor
//   valvula_agua, motor_lavagem, bomba, motor_centrifuga   actuators
//   fase                     current phase code
//   pausado, concluido, erro status flags
module controlador_ciclo
    import lavadora_pkg::*;
#(
    parameter int unsigned TEMPO_ENCHER_MAX  = TEMPO_ENCHER_MAX_PADRAO,
    parameter int unsigned TEMPO_MOLHO       = TEMPO_MOLHO_PADRAO,
    parameter int unsigned TEMPO_LAVAGEM     = TEMPO_LAVAGEM_PADRAO,
    parameter int unsigned TEMPO_DRENAR      = TEMPO_DRENAR_PADRAO,
    parameter int unsigned TEMPO_CENTRIFUGAR = TEMPO_CENTRIFUGAR_PADRAO
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       porta_fechada,
    input  logic       nivel_cheio,
    output logic       valvula_agua,
    output logic       motor_lavagem,
    output logic       bomba,
    output logic       motor_centrifuga,
    output logic [2:0] fase,
    output logic       pausado,
    output logic       concluido,
    output logic       erro
);

    fase_t r_estado;
    fase_t w_estado_prox;
    fase_t w_apos_encher;
    logic  r_pausado;
    logic  w_pausado_prox;
    logic  r_armado;
    logic  r_valvula;
    logic  r_motor_lavagem;
    logic  r_bomba;
    logic  r_motor_centrifuga;
    logic  r_concluido;
    logic  r_erro;
    logic  w_fim_tempo;
    logic  w_limpar;
    logic  w_habilitar;
    logic [LARGURA_CONT-1:0] w_terminal;

`ifdef CICLO_MOLHO_EN
    assign w_apos_encher = FASE_MOLHO;
`else
    assign w_apos_encher = FASE_LAVAR;
`endif

    always_comb begin
        w_terminal = '0;
        case (r_estado)
            FASE_ENCHER:      w_terminal = LARGURA_CONT'(TEMPO_ENCHER_MAX - 1);
            FASE_MOLHO:       w_terminal = LARGURA_CONT'(TEMPO_MOLHO - 1);
            FASE_LAVAR:       w_terminal = LARGURA_CONT'(TEMPO_LAVAGEM - 1);
            FASE_DRENAR:      w_terminal = LARGURA_CONT'(TEMPO_DRENAR - 1);
            FASE_CENTRIFUGAR: w_terminal = LARGURA_CONT'(TEMPO_CENTRIFUGAR - 1);
            default:          w_terminal = '0;
        endcase
    end

    // An active cycle on which the door is seen open still counts toward the
    // phase; only cycles spent with pausado=1 are frozen.
    assign w_habilitar = fase_temporizada(r_estado) && !r_pausado;
    assign w_limpar    = (w_estado_prox != r_estado);

    temporizador_fase u_temporizador (
        .i_clock     (clock),
        .i_reset_n   (reset_n),
        .i_limpar    (w_limpar),
        .i_habilitar (w_habilitar),
        .i_terminal  (w_terminal),
        .fim_tempo   (w_fim_tempo)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado  <= FASE_IDLE;
            r_pausado <= 1'b0;
        end else begin
            r_estado  <= w_estado_prox;
            r_pausado <= w_pausado_prox;
        end
    end

    always_comb begin
        w_estado_prox  = r_estado;
        w_pausado_prox = r_pausado;
        case (r_estado)
            FASE_IDLE: begin
                if (start && porta_fechada && r_armado) begin
                    w_estado_prox = FASE_ENCHER;
                end
            end
            FASE_FIM, FASE_ERRO: begin
                if (!start) begin
                    w_estado_prox = FASE_IDLE;
                end
            end
            default: begin
                if (r_pausado) begin
                    if (porta_fechada) begin
                        w_pausado_prox = 1'b0;
                    end
                end else if (!porta_fechada) begin
                    w_pausado_prox = 1'b1;
                end else begin
                    case (r_estado)
                        FASE_ENCHER: begin
                            if (nivel_cheio) begin
                                w_estado_prox = w_apos_encher;
                            end else if (w_fim_tempo) begin
                                w_estado_prox = FASE_ERRO;
                            end
                        end
                        FASE_MOLHO: begin
                            if (w_fim_tempo) w_estado_prox = FASE_LAVAR;
                        end
                        FASE_LAVAR: begin
                            if (w_fim_tempo) w_estado_prox = FASE_DRENAR;
                        end
                        FASE_DRENAR: begin
                            if (w_fim_tempo) w_estado_prox = FASE_CENTRIFUGAR;
                        end
                        FASE_CENTRIFUGAR: begin
                            if (w_fim_tempo) w_estado_prox = FASE_FIM;
                        end
                        default: begin
                        end
                    endcase
                end
            end
        endcase
    end

    // A new programme needs start to have been seen low since reset or since
    // the last programme began, so a start held through reset cannot restart.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_armado <= 1'b0;
        end else if (!start) begin
            r_armado <= 1'b1;
        end else if ((r_estado == FASE_IDLE) && (w_estado_prox == FASE_ENCHER)) begin
            r_armado <= 1'b0;
        end
    end

    // Outputs decoded from the next state so they move on the same edge as fase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valvula          <= 1'b0;
            r_motor_lavagem    <= 1'b0;
            r_bomba            <= 1'b0;
            r_motor_centrifuga <= 1'b0;
            r_concluido        <= 1'b0;
            r_erro             <= 1'b0;
        end else begin
            r_valvula          <= (w_estado_prox == FASE_ENCHER) && !w_pausado_prox;
            r_motor_lavagem    <= (w_estado_prox == FASE_LAVAR) && !w_pausado_prox;
            r_bomba            <= ((w_estado_prox == FASE_DRENAR) ||
                                   (w_estado_prox == FASE_CENTRIFUGAR)) && !w_pausado_prox;
            r_motor_centrifuga <= (w_estado_prox == FASE_CENTRIFUGAR) && !w_pausado_prox;
            r_concluido        <= (w_estado_prox == FASE_FIM);
            r_erro             <= (w_estado_prox == FASE_ERRO);
        end
    end

    assign valvula_agua     = r_valvula;
    assign motor_lavagem    = r_motor_lavagem;
    assign bomba            = r_bomba;
    assign motor_centrifuga = r_motor_centrifuga;
    assign fase             = r_estado;
    assign pausado          = r_pausado;
    assign concluido        = r_concluido;
    assign erro             = r_erro;

endmodule

// File: tb/tb_controlador_ciclo.sv
`timescale 1ns/1ps
module tb_controlador_ciclo;

    localparam int T_ENCHER = 20;
    localparam int T_MOLHO  = 4;
    localparam int T_LAVAR  = 5;
    localparam int T_DRENAR = 3;
    localparam int T_CENTRI = 6;
`ifdef CICLO_MOLHO_EN
    localparam bit COM_MOLHO = 1'b1;
`else
    localparam bit COM_MOLHO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       porta_fechada = 1'b1;
    logic       nivel_cheio = 1'b0;
    logic       valvula_agua, motor_lavagem, bomba, motor_centrifuga;
    logic [2:0] fase;
    logic       pausado, concluido, erro;

    controlador_ciclo #(
        .TEMPO_ENCHER_MAX  (T_ENCHER),
        .TEMPO_MOLHO       (T_MOLHO),
        .TEMPO_LAVAGEM     (T_LAVAR),
        .TEMPO_DRENAR      (T_DRENAR),
        .TEMPO_CENTRIFUGAR (T_CENTRI)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .porta_fechada    (porta_fechada),
        .nivel_cheio      (nivel_cheio),
        .valvula_agua     (valvula_agua),
        .motor_lavagem    (motor_lavagem),
        .bomba            (bomba),
        .motor_centrifuga (motor_centrifuga),
        .fase             (fase),
        .pausado          (pausado),
        .concluido        (concluido),
        .erro             (erro)
    );

    always #5 clock = ~clock;

    // Reference model: phase number, active cycles already consumed in it,
    // pause flag and "start seen low" flag.
    int m_ph   = 0;
    int m_used = 0;
    bit m_pz   = 1'b0;
    bit m_arm  = 1'b0;

    function automatic int dur(input int p);
        case (p)
            1: return T_ENCHER;
            2: return T_MOLHO;
            3: return T_LAVAR;
            4: return T_DRENAR;
            5: return T_CENTRI;
            default: return 1;
        endcase
    endfunction

    function automatic int seguinte(input int p);
        if (p == 1) return COM_MOLHO ? 2 : 3;
        return p + 1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = 0; m_used = 0; m_pz = 1'b0; m_arm = 1'b0;
        end else begin
            if (m_ph == 0) begin
                if (start && porta_fechada && m_arm) begin
                    m_ph = 1; m_used = 0; m_arm = 1'b0;
                end
            end else if (m_ph >= 6) begin
                if (!start) m_ph = 0;
            end else if (m_pz) begin
                if (porta_fechada) m_pz = 1'b0;
            end else if (porta_fechada && m_ph == 1 && nivel_cheio) begin
                m_ph = seguinte(1); m_used = 0;
            end else if (porta_fechada && (m_used + 1 >= dur(m_ph))) begin
                m_ph = (m_ph == 1) ? 7 : seguinte(m_ph); m_used = 0;
            end else begin
                m_used = m_used + 1;
                if (!porta_fechada) m_pz = 1'b1;
            end
            if (!start) m_arm = 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;
    int cnt_v = 0, cnt_m = 0, cnt_b = 0, cnt_s = 0, cnt_p = 0, cnt_soak = 0;
    int b_v, b_m, b_b, b_s, b_p, b_soak;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic snap();
        b_v = cnt_v; b_m = cnt_m; b_b = cnt_b; b_s = cnt_s; b_p = cnt_p; b_soak = cnt_soak;
    endtask

    // One cycle: advance to the falling edge, compare against the model,
    // update the activity counters used by the directed literal checks.
    task automatic tick();
        @(negedge clock);
        chk("fase", int'(fase), m_ph);
        chk("valvula", int'(valvula_agua), int'(m_ph == 1 && !m_pz));
        chk("motor_lavagem", int'(motor_lavagem), int'(m_ph == 3 && !m_pz));
        chk("bomba", int'(bomba), int'((m_ph == 4 || m_ph == 5) && !m_pz));
        chk("centrifuga", int'(motor_centrifuga), int'(m_ph == 5 && !m_pz));
        chk("pausado", int'(pausado), int'(m_pz));
        chk("concluido", int'(concluido), int'(m_ph == 6));
        chk("erro", int'(erro), int'(m_ph == 7));
        if (valvula_agua) cnt_v++;
        if (motor_lavagem) cnt_m++;
        if (bomba && !motor_centrifuga) cnt_b++;
        if (motor_centrifuga) cnt_s++;
        if (pausado) cnt_p++;
        if (fase == 3'd2) cnt_soak++;
    endtask

    task automatic esperar_fase(input int f, input int lim, input string nm);
        int n;
        n = 0;
        while (int'(fase) != f && n < lim) begin
            tick();
            n++;
        end
        chk(nm, int'(fase), f);
    endtask

    task automatic chk_saidas_zero(input string nm);
        chk({nm, "_fase"}, int'(fase), 0);
        chk({nm, "_act"}, int'({valvula_agua, motor_lavagem, bomba, motor_centrifuga}), 0);
        chk({nm, "_flags"}, int'({pausado, concluido, erro}), 0);
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk_saidas_zero("reset");
        reset_n = 1'b1;
        tick(); tick();

        // Nominal programme
        snap();
        start = 1'b1;
        esperar_fase(1, 5, "nom_encher");
        tick(); tick();
        nivel_cheio = 1'b1;
        tick();
        chk("nom_apos_encher", int'(fase), COM_MOLHO ? 2 : 3);
        esperar_fase(6, 80, "nom_fim");
        chk("nom_valvula_ciclos", cnt_v - b_v, 3);
        chk("nom_molho_ciclos", cnt_soak - b_soak, COM_MOLHO ? T_MOLHO : 0);
        chk("nom_lavagem_ciclos", cnt_m - b_m, 5);
        chk("nom_bomba_ciclos", cnt_b - b_b, 3);
        chk("nom_centrif_ciclos", cnt_s - b_s, 6);
        chk("nom_concluido", int'(concluido), 1);
        repeat (3) tick();
        chk("nom_fim_mantido", int'(fase), 6);
        start = 1'b0;
        nivel_cheio = 1'b0;
        tick();
        chk("nom_idle", int'(fase), 0);

        // Fill timeout
        snap();
        start = 1'b1;
        esperar_fase(7, 40, "tmo_erro");
        chk("tmo_valvula_ciclos", cnt_v - b_v, 20);
        chk("tmo_erro_flag", int'(erro), 1);
        tick();
        chk("tmo_erro_mantido", int'(fase), 7);
        start = 1'b0;
        tick();
        chk("tmo_idle", int'(fase), 0);

        // Door opened mid-wash
        start = 1'b1;
        esperar_fase(1, 5, "pz_encher");
        tick();
        nivel_cheio = 1'b1;
        esperar_fase(3, 20, "pz_lavar");
        snap();
        b_m = b_m - 1;  // the first wash cycle was already counted
        tick();
        porta_fechada = 1'b0;
        repeat (4) tick();
        porta_fechada = 1'b1;
        esperar_fase(4, 20, "pz_drenar");
        chk("pz_lavagem_ciclos", cnt_m - b_m, 5);
        chk("pz_pausa_ciclos", cnt_p - b_p, 4);
        esperar_fase(6, 40, "pz_fim");
        start = 1'b0;
        nivel_cheio = 1'b0;
        tick();

        // Reset during spin with start held
        start = 1'b1;
        esperar_fase(1, 5, "rst_encher");
        nivel_cheio = 1'b1;
        esperar_fase(5, 40, "rst_centrif");
        tick();
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1 chk_saidas_zero("rst_assinc");
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("rst_sem_reinicio", int'(fase), 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("rst_novo_pedido", int'(fase), 1);
        esperar_fase(6, 60, "rst_fim");
        start = 1'b0;
        nivel_cheio = 1'b0;
        tick();

        // Start with door open
        porta_fechada = 1'b0;
        start = 1'b1;
        repeat (3) tick();
        chk("porta_idle", int'(fase), 0);
        chk("porta_valvula", int'(valvula_agua), 0);
        porta_fechada = 1'b1;
        tick();
        chk("porta_encher", int'(fase), 1);
        nivel_cheio = 1'b1;
        esperar_fase(6, 60, "porta_fim");
        start = 1'b0;
        nivel_cheio = 1'b0;
        tick();

        // Randomised operation against the model
        for (int i = 0; i < 4000; i++) begin
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            if ($urandom_range(0, 19) == 0) start = ~start;
            porta_fechada = ($urandom_range(0, 9) != 0);
            nivel_cheio = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
